// File: rtl/register_file_pkg.sv
// Shared constants and types for the register file slice.
package regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/register_file_if.sv
// Bus between the core (master) and the register file (slave): two read ports, one write port.
interface register_file_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
);

  logic [ADDR_WIDTH-1:0] Read1;
  logic [ADDR_WIDTH-1:0] Read2;
  logic [ADDR_WIDTH-1:0] RD;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic                  finish_flag;
  logic [DATA_WIDTH-1:0] Data1;
  logic [DATA_WIDTH-1:0] Data2;

  modport master (
    output Read1, Read2, RD, WriteData, RegWrite, finish_flag,
    input  Data1, Data2
  );

  modport slave (
    input  Read1, Read2, RD, WriteData, RegWrite, finish_flag,
    output Data1, Data2
  );

endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port; index 0 is forced to zero regardless of storage contents.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
  output logic [DATA_WIDTH-1:0] data
);

  // Word select with x0 hardwired to zero
  always_comb begin
    data = '0;
    if (idx == '0) begin
      data = '0;
    end else begin
      data = regs[idx];
    end
  end

endmodule

// File: rtl/register_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file: two combinational reads, one synchronous write.
// Optional macro REGFILE_DUMP_EN prints all registers when finish_flag rises (simulation only).
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic             clock,
  input  logic             reset,
  register_file_if.slave   bus
);

  localparam int NUM_ENTRIES = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_r [NUM_ENTRIES];
  logic                  we_s;

  // Halt and x0 both suppress the write; there is no read bypass by design.
  assign we_s = bus.RegWrite && !bus.finish_flag && (bus.RD != '0);

  // Storage update: reset clears every entry and wins over a simultaneous write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we_s) begin
      regs_r[bus.RD] <= bus.WriteData;
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port1 (
    .idx  (bus.Read1),
    .regs (regs_r),
    .data (bus.Data1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port2 (
    .idx  (bus.Read2),
    .regs (regs_r),
    .data (bus.Data2)
  );

`ifdef REGFILE_DUMP_EN
  logic finish_prev_r;

  // Dump the whole file on the edge where finish_flag goes 0->1
  always_ff @(posedge clock) begin
    if (reset) begin
      finish_prev_r <= 1'b0;
    end else begin
      finish_prev_r <= bus.finish_flag;
    end
    if (!reset && bus.finish_flag && !finish_prev_r) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        $display("x%0d = %h", i, regs_r[i]);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: expected read values queued at stimulus, popped at sampling.
module tb_register_file;

  logic clock;
  logic reset;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks_cnt = 0;
  int          errors_cnt = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [32];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks_cnt++;
    if (obs !== expv) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Pop two expectations and compare them against both read ports
  task automatic sample_ports(input string tag);
    logic [31:0] e1;
    logic [31:0] e2;
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    check_value({tag, "_d1"}, bus.Data1, e1);
    check_value({tag, "_d2"}, bus.Data2, e2);
  endtask

  task automatic do_read(input string tag, input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] e1, input logic [31:0] e2);
    @(negedge clock);
    bus.Read1 = a;
    bus.Read2 = b;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    #1;
    sample_ports(tag);
  endtask

  task automatic do_write(input logic [4:0] rd, input logic [31:0] wd,
                          input logic we, input logic ff);
    @(negedge clock);
    bus.RD          = rd;
    bus.WriteData   = wd;
    bus.RegWrite    = we;
    bus.finish_flag = ff;
    @(posedge clock);
    if (we && !ff && rd != 5'd0) model[rd] = wd;
    #1;
    bus.RegWrite    = 1'b0;
    bus.finish_flag = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    bus.Read1       = 5'd0;
    bus.Read2       = 5'd0;
    bus.RD          = 5'd0;
    bus.WriteData   = 32'd0;
    bus.RegWrite    = 1'b0;
    bus.finish_flag = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_read("rst", 5'(2*i), 5'(2*i+1), 32'd0, 32'd0);
    end

    // Basic write/read and unwritten registers
    do_write(5'd3, 32'hABCDEFFF, 1'b1, 1'b0);
    do_write(5'd5, 32'hFBCDE111, 1'b1, 1'b0);
    do_read("basic", 5'd3, 5'd5, 32'hABCDEFFF, 32'hFBCDE111);
    do_read("unwr", 5'd7, 5'd10, 32'd0, 32'd0);

    // x0 hardwired
    do_write(5'd0, 32'hDEADBEEF, 1'b1, 1'b0);
    do_read("x0", 5'd0, 5'd0, 32'd0, 32'd0);

    // finish_flag blocks writes
    do_write(5'd3, 32'h12345678, 1'b1, 1'b1);
    do_read("halt", 5'd3, 5'd5, 32'hABCDEFFF, 32'hFBCDE111);

    // Read during write: old value before the edge, new value after
    do_write(5'd9, 32'h11111111, 1'b1, 1'b0);
    @(negedge clock);
    bus.Read1     = 5'd9;
    bus.Read2     = 5'd9;
    bus.RD        = 5'd9;
    bus.WriteData = 32'h22222222;
    bus.RegWrite  = 1'b1;
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h11111111);
    #1;
    sample_ports("rdw_pre");
    @(posedge clock);
    model[9] = 32'h22222222;
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h22222222);
    #1;
    bus.RegWrite = 1'b0;
    sample_ports("rdw_post");

    // Randomised traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [4:0] rd;
      logic [4:0] a;
      logic [4:0] b;
      rd = 5'($urandom_range(0, 31));
      do_write(rd, $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));
      a = 5'($urandom_range(0, 31));
      b = (n % 4 == 0) ? rd : 5'($urandom_range(0, 31));
      do_read("rand", a, b, model[a], model[b]);
    end

    // Reset priority over a simultaneous write
    do_write(5'd3, 32'hABCDEFFF, 1'b1, 1'b0);
    do_write(5'd5, 32'hFBCDE111, 1'b1, 1'b0);
    @(negedge clock);
    reset         = 1'b1;
    bus.RegWrite  = 1'b1;
    bus.RD        = 5'd4;
    bus.WriteData = 32'h00000005;
    @(posedge clock);
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    reset        = 1'b0;
    bus.RegWrite = 1'b0;
    do_read("rstpri_a", 5'd3, 5'd4, 32'd0, 32'd0);
    do_read("rstpri_b", 5'd5, 5'd4, 32'd0, 32'd0);
    for (int i = 0; i < 16; i++) begin
      do_read("rst2", 5'(2*i), 5'(2*i+1), model[2*i], model[2*i+1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

32-entry, 32-bit general-purpose register file for the single-cycle RISC-V core. It provides two combinational read ports for rs1/rs2 and one synchronous write port for rd. Register x0 is hardwired to zero. It sits between instruction decode, the ALU operand path and the write-back mux.

## Interface
- Clock and reset: one clock; reset is synchronous and active-high. The ports are named `clock` and `reset`.

Parameters:
- `DATA_WIDTH`, default 32: register width in bits.
- `ADDR_WIDTH`, default 5: register index width; the file holds 2**ADDR_WIDTH entries.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high; clears all registers.
- `Read1`  in  ADDR_WIDTH: read port 1 index (rs1).
- `Read2`  in  ADDR_WIDTH: read port 2 index (rs2).
- `RD`  in  ADDR_WIDTH: write index (rd).
- `WriteData`  in  DATA_WIDTH: write-back value.
- `RegWrite`  in  1: write enable.
- `finish_flag`  in  1: program-finished/halt indication; inhibits writes.
- `Data1`  out  DATA_WIDTH: contents of register `Read1`.
- `Data2`  out  DATA_WIDTH: contents of register `Read2`.

## Operation
- Storage is an array of 2**ADDR_WIDTH words.
- **Write:** on a rising `clock` edge with `RegWrite`=1, `finish_flag`=0, `reset`=0 and `RD`≠0, the register at `RD` takes `WriteData`.
- Writes to x0 are discarded silently.
- **Read:** `Data1` and `Data2` are purely combinational functions of `Read1`, `Read2` and the stored state.
- Index 0 always reads 0.
- Both ports may address the same register; both then return the same value.
- **Reset:** when `reset` is high at a rising edge, all registers become 0. Reset takes priority over a simultaneous write.
- Registers never written since reset read 0.
- **finish_flag=1:** all writes are blocked. Reads continue normally.
- Unknown or X index inputs are not required to produce defined outputs.

## Timing
- Write latency: the new value is visible on a read port after the rising edge that commits it, within the same cycle's combinational settle.
- Read during write, same index, same cycle: returns the old stored value. There is no internal bypass; forwarding is the core's responsibility.
- Read latency: zero cycles (combinational).
- Reset value of `Data1`/`Data2`: 0 for every index after the reset edge.
- Reset asserted mid-sequence: the next edge clears the whole file, regardless of `RegWrite`.

## Configuration
- Macro: `REGFILE_DUMP_EN`.
- **Defined:** on the rising edge where `finish_flag` transitions 0→1, the block prints all registers (index and hex value, one per line) via `$display`. This is simulation-only code inside `ifdef`.
- **Undefined:** no dump logic is compiled. Functional behaviour is identical in both cases.

## Structure
- Package `regfile_pkg` holds:
  - constants `XLEN`=32, `REG_ADDR_W`=5, `NUM_REGS`=32;
  - typedefs `word_t` (logic [XLEN-1:0]) and `reg_idx_t` (logic [REG_ADDR_W-1:0]).
- Module parameter defaults derive from these package constants.
- One sub-module, `regfile_read_port`: it takes an index and the storage array and returns the word, forcing 0 for index 0. It is instantiated twice, once per read port.

## Test plan
- **Basic write/read:** reset, then write x3=0xABCDEFFF and x5=0xFBCDE111 with `RegWrite`=1. Then set `RegWrite`=0, `Read1`=3, `Read2`=5 → `Data1`=0xABCDEFFF, `Data2`=0xFBCDE111.
- **Unwritten registers:** after the above, `Read1`=7, `Read2`=10 → `Data1`=0, `Data2`=0.
- **x0 hardwired:** write x0=0xDEADBEEF, then read `Read1`=0 → `Data1`=0.
- **finish_flag blocks writes:** with `finish_flag`=1, write x3=0x12345678, then read x3 → 0xABCDEFFF. With `REGFILE_DUMP_EN`, the dump shows x3=abcdefff and x5=fbcde111.
- **Read during write:** x9 holds 0x11111111. Write x9=0x22222222 while `Read1`=9 → `Data1`=0x11111111 before the edge and 0x22222222 after it.
- **Reset priority:** assert `reset` and `RegWrite` together with `RD`=4, `WriteData`=0x5 → after the edge, x3, x4 and x5 all read 0.
